gpu_ram_arb: RTL and testbench
==============================

Name: gpu_ram_arb

Overview:
- Two-port arbiter and command pipeline directly upstream of the GPU local RAM (4 KB, 1024 x 32).
- Merges GPU-internal load/store/prefetch traffic with external-bus (CPU/blitter) accesses into one registered RAM command stream: ram_addr[11:2], gpu_memw, ramen, write data.
- Returns RAM read data to whichever requester issued the read.

Parameters:
- AW, 10, word-address width (ram_addr[11:2]).
- DW, 32, data width.
- STARVE_MAX, 4, maximum consecutive internal grants while an external request waits.

Ports:
- clk  in  1  system clock, single clock domain.
- resetl  in  1  asynchronous active-low reset.
- int_req  in  1  internal access request.
- int_we  in  1  internal write (1) / read (0).
- int_addr  in  AW  internal word address.
- int_wdata  in  DW  internal write data.
- int_ack  out  1  internal request accepted this cycle.
- int_rvalid  out  1  internal read data valid.
- int_rdata  out  DW  internal read data.
- ext_req, ext_we, ext_addr, ext_wdata, ext_ack, ext_rvalid, ext_rdata: same directions, widths and meanings as the int_* ports, for the external port.
- ram_addr  out  AW  RAM word address.
- ramen  out  1  RAM access enable.
- gpu_memw  out  1  RAM write strobe.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid one cycle after a read command.

Behaviour:
- Reset (async, resetl=0): all outputs 0, starve counter 0, pipeline valid bits 0, write buffer empty. Reset mid-transaction drops it with no rvalid; requesters reissue.
- Arbitration (combinational, cycle N):
  - Internal wins by default.
  - External wins when ext_req=1 and either int_req=0 or starve_cnt==STARVE_MAX.
  - Exactly one ack per cycle at most. ack = grant.
- starve_cnt:
  - Increments on each internal grant while ext_req=1.
  - Clears on any external grant or when ext_req=0.
  - Saturates at STARVE_MAX.
- Command stage (cycle N+1): on grant, register ramen=1, gpu_memw=we, ram_addr, ram_wdata and an owner bit. With no grant, ramen=0 and gpu_memw=0; addr/wdata hold.
- Read return (cycle N+2): if the command was a read, pulse the owner's rvalid for one cycle with rdata=ram_rdata. The other port's rvalid stays 0. Non-owner rdata holds its last value.
- Writes produce no rvalid.
- Read latency is 2 cycles from ack.
- Throughput: one access per cycle, back-to-back, with no bubbles between ports.
- Requester holds req/we/addr/wdata stable until ack. Dropping req without ack is legal.
- Simultaneous requests to the same address: order follows grant order. A read granted after a write sees the new data.
- Address wrap: ram_addr is a 10-bit value. No bounds check; 0x3FF followed by 0x000 is legal.

Optional Feature:
- Macro: GPU_RAM_ARB_WBUF_EN.
- Enabled:
  - One-entry posted write buffer on the external port.
  - ext write with buffer empty is acked the same cycle and captured.
  - The buffer drains as an external grant on the first cycle int_req=0, or when starve_cnt==STARVE_MAX.
  - ext_ack stays 0 for any ext request while the buffer is full.
  - An internal read hitting the buffered address is forwarded from the buffer; int_rvalid keeps the same 2-cycle latency.
- Disabled: ext writes are acked only on arbitration grant. No forwarding logic.

Decomposition:
- Package gpu_ram_pkg: GPU_RAM_AW=10, GPU_RAM_DW=32, owner enum (OWN_INT=0, OWN_EXT=1), command struct typedef {valid, we, owner, addr, wdata}.
- One natural sub-module, gpu_ram_wbuf: the write buffer with its address-match forwarding, instantiated only under GPU_RAM_ARB_WBUF_EN.

Test Plan:
- Reset, then internal write 0x0AB to addr 0x010, then internal read of 0x010:
  - int_ack is seen in both cycles.
  - ramen/gpu_memw=1 one cycle after the first ack.
  - int_rvalid two cycles after the read ack, with int_rdata=0x0000_00AB.
- int_req held 1 continuously, ext_req=1 read of 0x3FF:
  - The first 4 cycles grant internal; the 5th grants external.
  - ext_rvalid 2 cycles later; starve_cnt returns to 0.
- Alternating int read 0x001 / ext read 0x002 every cycle: ramen stays 1 continuously, and each rvalid pulses only on the correct port.
- resetl pulsed low while a read is in the command stage: no rvalid follows, and all outputs read 0 during reset.
- Internal write to 0x3FF, then a read of 0x000 the next cycle: ram_addr sequence 0x3FF, 0x000 with no stall.
- (WBUF_EN) With int_req=1 continuously, ext write 0x55 to addr 0x020:
  - ext_ack in the same cycle; a second ext write stalls.
  - Internal read of 0x020 returns 0x55 via forwarding.
  - The drain occurs at the starve limit.

Source files
------------

// File: rtl/gpu_ram_pkg.sv
// rtl/gpu_ram_pkg.sv - shared widths, owner encoding and command record for the GPU RAM arbiter
package gpu_ram_pkg;

    localparam int GPU_RAM_AW = 10;
    localparam int GPU_RAM_DW = 32;

    typedef enum logic {
        OWN_INT = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        owner_e                owner;
        logic [GPU_RAM_AW-1:0] addr;
        logic [GPU_RAM_DW-1:0] wdata;
    } ram_cmd_t;

endpackage

// File: rtl/gpu_ram_wbuf.sv
// rtl/gpu_ram_wbuf.sv - one-entry posted write buffer for the external port with address-match lookup
module gpu_ram_wbuf
    import gpu_ram_pkg::*;
#(
    parameter int AW = GPU_RAM_AW,
    parameter int DW = GPU_RAM_DW
) (
    input  logic          clk,
    input  logic          resetl,
    input  logic          capture,
    input  logic [AW-1:0] cap_addr,
    input  logic [DW-1:0] cap_wdata,
    input  logic          drain,
    input  logic          kill,
    input  logic [AW-1:0] lookup_addr,
    output logic          full,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    output logic          hit
);

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            full  <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else if (capture) begin
            full  <= 1'b1;
            addr  <= cap_addr;
            wdata <= cap_wdata;
        end else if (drain || kill) begin
            // A later internal write to the same word supersedes the posted data.
            full  <= 1'b0;
        end
    end

    assign hit = full && (addr == lookup_addr);

endmodule

// File: rtl/gpu_ram_arb.sv
// rtl/gpu_ram_arb.sv - internal/external RAM arbiter and 2-stage command pipeline
// Optional posted external write buffer: GPU_RAM_ARB_WBUF_EN
module gpu_ram_arb
    import gpu_ram_pkg::*;
#(
    parameter int AW         = GPU_RAM_AW,
    parameter int DW         = GPU_RAM_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          resetl,
    input  logic          int_req,
    input  logic          int_we,
    input  logic [AW-1:0] int_addr,
    input  logic [DW-1:0] int_wdata,
    output logic          int_ack,
    output logic          int_rvalid,
    output logic [DW-1:0] int_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ramen,
    output logic          gpu_memw,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;
    logic          starve_hit;
    logic          ext_pend;
    logic          ext_src_we;
    logic [AW-1:0] ext_src_addr;
    logic [DW-1:0] ext_src_wdata;
    logic          grant_int;
    logic          grant_ext;
    logic          fwd_d;
    logic [DW-1:0] fwd_wdata;

    ram_cmd_t      cmd_d;
    ram_cmd_t      cmd_q;
    logic          cmd_fwd;
    logic [DW-1:0] cmd_fwd_data;
    logic          rd_valid;
    logic          rd_fwd;
    owner_e        rd_owner;
    logic [DW-1:0] rd_fwd_data;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] int_rdata_q;
    logic [DW-1:0] ext_rdata_q;

    assign starve_hit = (starve_cnt == SW'(STARVE_MAX));
    assign grant_ext  = resetl && ext_pend && (!int_req || starve_hit);
    assign grant_int  = resetl && int_req && !grant_ext;
    assign int_ack    = grant_int;

`ifdef GPU_RAM_ARB_WBUF_EN
    logic          wb_full;
    logic          wb_hit;
    logic          wb_post;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdata;

    // While the buffer holds data it is the only external source; new ext requests wait.
    assign wb_post       = resetl && ext_req && ext_we && !wb_full;
    assign ext_pend      = wb_full || (ext_req && !ext_we);
    assign ext_src_we    = wb_full;
    assign ext_src_addr  = wb_full ? wb_addr : ext_addr;
    assign ext_src_wdata = wb_full ? wb_wdata : ext_wdata;
    assign ext_ack       = wb_post || (grant_ext && !wb_full);
    assign fwd_d         = grant_int && !int_we && wb_hit;
    assign fwd_wdata     = wb_wdata;

    gpu_ram_wbuf #(
        .AW (AW),
        .DW (DW)
    ) u_wbuf (
        .clk         (clk),
        .resetl      (resetl),
        .capture     (wb_post),
        .cap_addr    (ext_addr),
        .cap_wdata   (ext_wdata),
        .drain       (grant_ext && wb_full),
        .kill        (grant_int && int_we && wb_hit),
        .lookup_addr (int_addr),
        .full        (wb_full),
        .addr        (wb_addr),
        .wdata       (wb_wdata),
        .hit         (wb_hit)
    );
`else
    assign ext_pend      = ext_req;
    assign ext_src_we    = ext_we;
    assign ext_src_addr  = ext_addr;
    assign ext_src_wdata = ext_wdata;
    assign ext_ack       = grant_ext;
    assign fwd_d         = 1'b0;
    assign fwd_wdata     = '0;
`endif

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            starve_cnt <= '0;
        end else if (!ext_pend || grant_ext) begin
            starve_cnt <= '0;
        end else if (grant_int && !starve_hit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        cmd_d       = cmd_q;
        cmd_d.valid = grant_int || grant_ext;
        if (grant_ext) begin
            cmd_d.we    = ext_src_we;
            cmd_d.owner = OWN_EXT;
            cmd_d.addr  = GPU_RAM_AW'(ext_src_addr);
            cmd_d.wdata = GPU_RAM_DW'(ext_src_wdata);
        end else if (grant_int) begin
            cmd_d.we    = int_we;
            cmd_d.owner = OWN_INT;
            cmd_d.addr  = GPU_RAM_AW'(int_addr);
            cmd_d.wdata = GPU_RAM_DW'(int_wdata);
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            cmd_q        <= '0;
            cmd_fwd      <= 1'b0;
            cmd_fwd_data <= '0;
            rd_valid     <= 1'b0;
            rd_fwd       <= 1'b0;
            rd_owner     <= OWN_INT;
            rd_fwd_data  <= '0;
            int_rdata_q  <= '0;
            ext_rdata_q  <= '0;
        end else begin
            cmd_q        <= cmd_d;
            cmd_fwd      <= fwd_d;
            cmd_fwd_data <= fwd_wdata;
            rd_valid     <= cmd_q.valid && !cmd_q.we;
            rd_fwd       <= cmd_fwd;
            rd_owner     <= cmd_q.owner;
            rd_fwd_data  <= cmd_fwd_data;
            int_rdata_q  <= int_rdata;
            ext_rdata_q  <= ext_rdata;
        end
    end

    assign ramen     = cmd_q.valid;
    assign gpu_memw  = cmd_q.valid && cmd_q.we;
    assign ram_addr  = AW'(cmd_q.addr);
    assign ram_wdata = DW'(cmd_q.wdata);

    // RAM data arrives combinationally in the return cycle; outside it each port holds its last word.
    assign rd_data    = rd_fwd ? rd_fwd_data : ram_rdata;
    assign int_rvalid = rd_valid && (rd_owner == OWN_INT);
    assign ext_rvalid = rd_valid && (rd_owner == OWN_EXT);
    assign int_rdata  = int_rvalid ? rd_data : int_rdata_q;
    assign ext_rdata  = ext_rvalid ? rd_data : ext_rdata_q;

endmodule

// File: tb/tb_gpu_ram_arb.sv
// tb/tb_gpu_ram_arb.sv - directed self-checking bench for gpu_ram_arb with a synchronous RAM model
module tb_gpu_ram_arb;

    logic        clk;
    logic        resetl;
    logic        int_req, int_we, int_ack, int_rvalid;
    logic [9:0]  int_addr;
    logic [31:0] int_wdata, int_rdata;
    logic        ext_req, ext_we, ext_ack, ext_rvalid;
    logic [9:0]  ext_addr;
    logic [31:0] ext_wdata, ext_rdata;
    logic [9:0]  ram_addr;
    logic        ramen, gpu_memw;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [1024];
    int          n_checks = 0;
    int          n_fail   = 0;

    gpu_ram_arb dut (
        .clk        (clk),
        .resetl     (resetl),
        .int_req    (int_req),
        .int_we     (int_we),
        .int_addr   (int_addr),
        .int_wdata  (int_wdata),
        .int_ack    (int_ack),
        .int_rvalid (int_rvalid),
        .int_rdata  (int_rdata),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_ack    (ext_ack),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .ram_addr   (ram_addr),
        .ramen      (ramen),
        .gpu_memw   (gpu_memw),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ramen) begin
            if (gpu_memw) mem[ram_addr] <= ram_wdata;
            else          ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        #4;
    endtask

    task automatic idle;
        int_req = 0; int_we = 0; int_addr = '0; int_wdata = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h000] = 32'h0000_00C0;
        mem[10'h001] = 32'h1111_1111;
        mem[10'h002] = 32'h2222_2222;
        mem[10'h005] = 32'h0000_5555;
        mem[10'h3FF] = 32'hDEAD_BEEF;
        ram_rdata = 32'h0;
        idle();
        resetl = 0;

        // Reset: outputs stay 0 even with a request asserted
        tick(); int_req = 1; mid();
        chk("rst_int_ack", {31'b0, int_ack}, 0);
        chk("rst_ramen", {31'b0, ramen}, 0);
        chk("rst_rvalid", {30'b0, int_rvalid, ext_rvalid}, 0);
        chk("rst_rdata", int_rdata | ext_rdata, 0);
        chk("rst_addr", {22'b0, ram_addr}, 0);
        chk("rst_starve", 32'(dut.starve_cnt), 0);
        idle();
        tick(); resetl = 1;

        // Internal write 0xAB to 0x010 then read back
        tick(); int_req = 1; int_we = 1; int_addr = 10'h010; int_wdata = 32'hAB; mid();
        chk("wr_ack", {31'b0, int_ack}, 1);
        tick(); int_we = 0; mid();
        chk("rd_ack", {31'b0, int_ack}, 1);
        chk("wr_cmd", {30'b0, ramen, gpu_memw}, 2'b11);
        chk("wr_addr", {22'b0, ram_addr}, 32'h010);
        chk("wr_data", ram_wdata, 32'hAB);
        tick(); idle(); mid();
        chk("rd_cmd", {30'b0, ramen, gpu_memw}, 2'b10);
        chk("rd_early", {31'b0, int_rvalid}, 0);
        tick(); mid();
        chk("rd_rvalid", {30'b0, int_rvalid, ext_rvalid}, 2'b10);
        chk("rd_rdata", int_rdata, 32'h0000_00AB);
        tick(); mid();
        chk("rd_pulse", {31'b0, int_rvalid}, 0);
        chk("rd_hold", int_rdata, 32'h0000_00AB);

        // Starvation limit: four internal grants, then external
        tick(); int_req = 1; int_addr = 10'h005; ext_req = 1; ext_addr = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("starve_int", {30'b0, int_ack, ext_ack}, 2'b10);
            tick();
        end
        mid();
        chk("starve_ext", {30'b0, int_ack, ext_ack}, 2'b01);
        tick(); ext_req = 0; mid();
        chk("starve_clr", 32'(dut.starve_cnt), 0);
        chk("ext_cmd_addr", {22'b0, ram_addr}, 32'h3FF);
        chk("ext_cmd", {30'b0, ramen, gpu_memw}, 2'b10);
        tick(); int_req = 0; mid();
        chk("ext_rvalid", {30'b0, int_rvalid, ext_rvalid}, 2'b01);
        chk("ext_rdata", ext_rdata, 32'hDEAD_BEEF);
        tick(); mid();
        chk("int_after_ext", {30'b0, int_rvalid, ext_rvalid}, 2'b10);
        chk("int_after_data", int_rdata, 32'h0000_5555);
        chk("ext_hold", ext_rdata, 32'hDEAD_BEEF);
        tick(); idle();

        // Alternating int read 0x001 / ext read 0x002 every cycle
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i < 4) begin
                if (i % 2 == 0) begin int_req = 1; int_addr = 10'h001; end
                else            begin ext_req = 1; ext_addr = 10'h002; end
            end
            mid();
            if (i < 4) chk("alt_ack", {30'b0, int_ack, ext_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i >= 1 && i <= 4) chk("alt_ramen", {31'b0, ramen}, 1);
            if (i >= 2) begin
                chk("alt_rvalid", {30'b0, int_rvalid, ext_rvalid}, (i % 2 == 0) ? 2'b10 : 2'b01);
                if (i % 2 == 0) chk("alt_int_data", int_rdata, 32'h1111_1111);
                else            chk("alt_ext_data", ext_rdata, 32'h2222_2222);
            end
            tick();
        end

        // Reset while a read sits in the command stage
        int_req = 1; int_addr = 10'h001; mid();
        chk("rr_ack", {31'b0, int_ack}, 1);
        tick(); mid();
        chk("rr_cmd", {31'b0, ramen}, 1);
        #1 resetl = 0; #1;
        chk("rr_rst_out", {28'b0, int_ack, ext_ack, ramen, gpu_memw}, 0);
        chk("rr_rst_addr", {22'b0, ram_addr}, 0);
        chk("rr_rst_rdata", int_rdata, 0);
        tick(); mid();
        chk("rr_no_rvalid", {30'b0, int_rvalid, ext_rvalid}, 0);
        idle(); resetl = 1;
        tick(); mid();
        chk("rr_no_rvalid2", {30'b0, int_rvalid, ext_rvalid}, 0);

        // Address wrap: write 0x3FF then read 0x000 back to back
        tick(); int_req = 1; int_we = 1; int_addr = 10'h3FF; int_wdata = 32'h77; mid();
        chk("wrap_ack0", {31'b0, int_ack}, 1);
        tick(); int_we = 0; int_addr = 10'h000; mid();
        chk("wrap_ack1", {31'b0, int_ack}, 1);
        chk("wrap_addr0", {22'b0, ram_addr}, 32'h3FF);
        chk("wrap_w", {30'b0, ramen, gpu_memw}, 2'b11);
        tick(); idle(); mid();
        chk("wrap_addr1", {22'b0, ram_addr}, 32'h000);
        chk("wrap_r", {30'b0, ramen, gpu_memw}, 2'b10);
        tick(); mid();
        chk("wrap_rdata", int_rdata, 32'h0000_00C0);

`ifdef GPU_RAM_ARB_WBUF_EN
        // Posted ext write, forwarding to an internal read, drain at the starve limit
        tick(); int_req = 1; int_addr = 10'h005;
        ext_req = 1; ext_we = 1; ext_addr = 10'h020; ext_wdata = 32'h55; mid();
        chk("wb_post_ack", {30'b0, int_ack, ext_ack}, 2'b11);
        tick(); int_addr = 10'h020; ext_addr = 10'h021; ext_wdata = 32'h66; mid();
        chk("wb_stall1", {30'b0, int_ack, ext_ack}, 2'b10);
        tick(); int_addr = 10'h005; mid();
        chk("wb_stall2", {30'b0, int_ack, ext_ack}, 2'b10);
        tick(); mid();
        chk("wb_stall3", {30'b0, int_ack, ext_ack}, 2'b10);
        chk("wb_fwd_valid", {31'b0, int_rvalid}, 1);
        chk("wb_fwd_data", int_rdata, 32'h55);
        tick(); mid();
        chk("wb_stall4", {30'b0, int_ack, ext_ack}, 2'b10);
        tick(); mid();
        chk("wb_drain", {30'b0, int_ack, ext_ack}, 2'b00);
        tick(); mid();
        chk("wb_drain_cmd", {30'b0, ramen, gpu_memw}, 2'b11);
        chk("wb_drain_addr", {22'b0, ram_addr}, 32'h020);
        chk("wb_drain_data", ram_wdata, 32'h55);
        chk("wb_post2", {31'b0, ext_ack}, 1);
        tick(); idle();
        tick(); tick(); tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
